// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared widths and FSM state type for the AES-CTR controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int NONCE_W = 96;
    localparam int CTR_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } aes_state_e;

endpackage

`default_nettype wire

// File: rtl/aes_ctr_counter.sv
// ============================================================================
// Module      : aes_ctr_counter
// Description : 32-bit CTR block counter with base capture and sticky wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_ctr_counter
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             inc,
    output logic [CTR_W-1:0] ctr,
    output logic             wrap
);

    logic [CTR_W-1:0] ctr_reg;
    logic [CTR_W-1:0] ctr_base;
    logic [CTR_W-1:0] ctr_next;

    assign ctr_next = ctr_reg + CTR_W'(1);
    assign ctr      = ctr_reg;

    // Wrap means the counter has come all the way round to its starting value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_reg  <= '0;
            ctr_base <= '0;
            wrap     <= 1'b0;
        end else if (load) begin
            ctr_reg  <= load_val;
            ctr_base <= load_val;
            wrap     <= 1'b0;
        end else if (inc) begin
            ctr_reg <= ctr_next;
            if (ctr_next == ctr_base) begin
                wrap <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_ctr_ctrl.sv
// ============================================================================
// Module      : aes_ctr_ctrl
// Description : AES-CTR block sequencer around an external AES core.
//               Define AES_CTR_WRAP_GUARD_EN to refuse new blocks after wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_ctr_ctrl
    import aes_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NONCE_W-1:0] nonce_i,
    input  logic [CTR_W-1:0]   ctr_init_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic               data_valid_i,
    output logic               data_ready_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               data_valid_o,
    input  logic               data_ready_i,
    output logic               core_en_o,
    output logic [BLOCK_W-1:0] core_block_o,
    input  logic [BLOCK_W-1:0] core_block_i,
    input  logic               core_done_i,
    output logic               ctr_wrap_o
);

    aes_state_e         state;
    logic [NONCE_W-1:0] nonce_reg;
    logic [BLOCK_W-1:0] data_reg;
    logic [CTR_W-1:0]   ctr_val;
    logic               ctr_load;
    logic               ctr_inc;
    logic               accept;
    logic               block_stop;

`ifdef AES_CTR_WRAP_GUARD_EN
    assign block_stop = ctr_wrap_o;
`else
    assign block_stop = 1'b0;
`endif

    // A start request takes priority over data in the same IDLE cycle.
    assign data_ready_o = (state == IDLE) & ~start_i & ~block_stop;
    assign accept       = data_valid_i & data_ready_o;
    assign ctr_load     = (state == IDLE) & start_i;
    assign ctr_inc      = (state == RUN) & core_done_i;
    assign core_block_o = {nonce_reg, ctr_val};

    aes_ctr_counter u_ctr (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (ctr_load),
        .load_val (ctr_init_i),
        .inc      (ctr_inc),
        .ctr      (ctr_val),
        .wrap     (ctr_wrap_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            nonce_reg    <= '0;
            data_reg     <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            core_en_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctr_load) begin
                        nonce_reg <= nonce_i;
                    end
                    if (accept) begin
                        data_reg  <= data_i;
                        core_en_o <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (core_done_i) begin
                        data_o       <= core_block_i ^ data_reg;
                        core_en_o    <= 1'b0;
                        data_valid_o <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (data_ready_i) begin
                        data_valid_o <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    core_en_o    <= 1'b0;
                    data_valid_o <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/aes_ctr_ctrl.md
AES_CTR_CTRL -- requirements
Module: aes_ctr_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start_i  in  1  load nonce/counter; nonce_i  in  96  IV nonce; ctr_init_i  in  32  initial counter.
REQ-004 SHALL have ports: data_i  in  128  plaintext block; data_valid_i  in  1; data_ready_o  out  1.
REQ-005 SHALL have ports: data_o  out  128  ciphertext block; data_valid_o  out  1; data_ready_i  in  1.
REQ-006 SHALL have ports: core_en_o  out  1  AES core enable; core_block_o  out  128  counter block to core plaintext_i; core_block_i  in  128  core ciphertext_o; core_done_i  in  1  core done_o.
REQ-007 SHALL have ports: ctr_wrap_o  out  1  sticky counter-wrap flag.

Function
REQ-008 SHALL run FSM states IDLE, RUN, OUT.
REQ-009 SHALL, in IDLE with start_i=1, load nonce_reg<=nonce_i, ctr_reg<=ctr_init_i, ctr_base<=ctr_init_i, clear ctr_wrap_o; start_i outside IDLE is ignored.
REQ-010 SHALL drive data_ready_o = (state==IDLE) & ~start_i & ~block_stop, where block_stop is defined in REQ-020.
REQ-011 SHALL, on data_valid_i & data_ready_o, capture data_i into data_reg and enter RUN next cycle.
REQ-012 SHALL hold core_en_o=1 and core_block_o={nonce_reg, ctr_reg} for every cycle in RUN; core_en_o=0 in all other states.
REQ-013 SHALL, in RUN on the first cycle core_done_i=1, register data_o<=core_block_i ^ data_reg, set ctr_reg<=ctr_reg+1 (mod 2^32), and enter OUT.
REQ-014 SHALL assert data_valid_o=1 exactly while in OUT, with data_o stable.
REQ-015 SHALL leave OUT for IDLE on data_ready_i=1; data_valid_o drops the next cycle.
REQ-016 SHALL ignore core_done_i outside RUN.
REQ-017 SHALL give a latency of 1 cycle from acceptance to core_en_o, then N+1 cycles to data_valid_o, where N is the cycle count until core_done_i.
REQ-018 SHALL, when ctr_reg+1 equals ctr_base, set ctr_wrap_o=1 (sticky until start_i or reset).

Reset
REQ-019 SHALL, on rst_i=1 at a clock edge in any state including RUN, enter IDLE and zero nonce_reg, ctr_reg, ctr_base, data_reg, data_o, and set data_valid_o=0, core_en_o=0, ctr_wrap_o=0; data_ready_o=1 after reset release.

Configuration
REQ-020 SHALL, with AES_CTR_WRAP_GUARD_EN defined, set block_stop=ctr_wrap_o, refusing new blocks after wrap until start_i; without it, block_stop=0 and the counter wraps silently while ctr_wrap_o still flags.

Structure
REQ-021 SHALL take the state enum type and BLOCK_W=128, NONCE_W=96, CTR_W=32 from shared package aes_pkg.
REQ-022 SHALL place the counter register, increment and wrap compare in sub-module aes_ctr_counter.

Verification
REQ-023 SHALL check reset: rst_i=1 mid-RUN -> next cycle state IDLE, core_en_o=0, data_valid_o=0, data_o=0, ctr_wrap_o=0.
REQ-024 SHALL check the SP800-38A AES-256 CTR vector with key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, nonce f0f1f2f3f4f5f6f7f8f9fafb, ctr fcfdfeff, data 6bc1bee22e409f96e93d7e117393172a -> data_o 601ec313775789a5b7a7f504bbf3d228.
REQ-025 SHALL check the second block: data ae2d8a571e03ac9c9eb76fac45af8e51 -> core_block_o ends fcfdff00, data_o f443e3ca4d62b59aca84e990cacaf5c5.
REQ-026 SHALL check backpressure: data_ready_i=0 for 5 cycles in OUT -> data_valid_o=1, data_o unchanged, data_ready_o=0, core_en_o=0.
REQ-027 SHALL check wrap: ctr_init ffffffff, 2^32 blocks via forced ctr_base=00000001 shortcut -> after wrap ctr_wrap_o=1; with AES_CTR_WRAP_GUARD_EN defined data_ready_o=0 until start_i.
REQ-028 SHALL check simultaneous events: start_i=1 and data_valid_i=1 in IDLE -> counter loaded, data not accepted, data accepted the following cycle.
